// File: rtl/lidar_voxel_pkg.sv
// Shared definitions for the LiDAR voxel pipeline: voxel word layout,
// count saturation value and the read-modify-write sequencer states.
package lidar_voxel_pkg;

    localparam int CNT_MSB = 31;
    localparam int CNT_LSB = 16;
    localparam int INT_MSB = 15;
    localparam int INT_LSB = 0;

    localparam logic [15:0] CNT_SAT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4
    } seq_state_t;

endpackage

// File: rtl/voxel_update_alu.sv
// Combinational voxel word update: bumps the saturating point count and
// keeps the larger of the stored and incoming intensities.
module voxel_update_alu
    import lidar_voxel_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [15:0] intensity,
    output logic [31:0] new_word
);

    logic [15:0] old_cnt;
    logic [15:0] old_int;
    logic [15:0] new_cnt;
    logic [15:0] new_int;

    // Split the word, saturate the count, take the unsigned maximum intensity.
    always_comb begin
        old_cnt  = old_word[CNT_MSB:CNT_LSB];
        old_int  = old_word[INT_MSB:INT_LSB];
        new_cnt  = (old_cnt == CNT_SAT) ? CNT_SAT : old_cnt + 16'd1;
        new_int  = (intensity > old_int) ? intensity : old_int;
        new_word = {new_cnt, new_int};
    end

endmodule

// File: rtl/voxel_rmw_sequencer.sv
// Serialized read-modify-write of voxel words through the cache manager.
// One point at a time: read the word, update count/max intensity, write it
// back. A wait-state timer drops the point if the cache manager stalls.
module voxel_rmw_sequencer
    import lidar_voxel_pkg::*;
#(
    parameter int ADDR_W         = 15,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int STAT_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pt_valid,
    output logic              pt_ready,
    input  logic [ADDR_W-1:0] pt_voxel_addr,
    input  logic [15:0]       pt_intensity,
    output logic [ADDR_W-1:0] cm_voxel_addr,
    output logic [DATA_W-1:0] cm_data_wr,
    output logic              cm_read_en,
    output logic              cm_write_en,
    input  logic [DATA_W-1:0] cm_data_rd,
    input  logic              cm_ready,
    output logic              busy,
    output logic              timeout_err,
    output logic [STAT_W-1:0] points_done
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    seq_state_t        state;
    seq_state_t        next_state;

    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       int_q;
    logic [DATA_W-1:0] word_q;
    logic [TMR_W-1:0]  timer;
    logic [STAT_W-1:0] done_cnt;
    logic              err_q;

    logic              accept;
    logic              capture;
    logic              commit;
    logic              abort;
    logic              timer_clr;
    logic              timer_run;
    logic              timeout_hit;
    logic [31:0]       alu_word;

    voxel_update_alu u_alu (
        .old_word  (cm_data_rd),
        .intensity (int_q),
        .new_word  (alu_word)
    );

    assign timer_run   = (state == RD_WAIT) || (state == WR_WAIT);
    assign timeout_hit = (timer == TMR_W'(TIMEOUT_CYCLES - 1));

    // State register; reset returns to IDLE and abandons any point in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and request strobes; pt_ready is gated by reset so it stays low while held.
    always_comb begin
        next_state  = state;
        pt_ready    = 1'b0;
        cm_read_en  = 1'b0;
        cm_write_en = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        commit      = 1'b0;
        abort       = 1'b0;
        timer_clr   = 1'b0;
        case (state)
            IDLE: begin
                pt_ready = rst;
                if (pt_valid && rst) begin
                    accept     = 1'b1;
                    next_state = RD_REQ;
                end
            end
            RD_REQ: begin
                cm_read_en = 1'b1;
                timer_clr  = 1'b1;
                next_state = RD_WAIT;
            end
            RD_WAIT: begin
                if (cm_ready) begin
                    capture    = 1'b1;
                    next_state = WR_REQ;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            WR_REQ: begin
                cm_write_en = 1'b1;
                timer_clr   = 1'b1;
                next_state  = WR_WAIT;
            end
            WR_WAIT: begin
                if (cm_ready) begin
                    commit     = 1'b1;
                    next_state = IDLE;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Point latch, updated word, wait timer, sticky error and completion counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q   <= '0;
            int_q    <= '0;
            word_q   <= '0;
            timer    <= '0;
            done_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= pt_voxel_addr;
                int_q  <= pt_intensity;
            end
            if (timer_clr) begin
                timer <= '0;
            end else if (timer_run) begin
                timer <= timer + 1'b1;
            end
            if (capture) begin
                word_q <= alu_word;
            end
            if (commit) begin
                done_cnt <= done_cnt + 1'b1;
            end
            if (abort) begin
                err_q <= 1'b1;
            end
        end
    end

    assign cm_voxel_addr = addr_q;
    assign cm_data_wr    = word_q;
    assign busy          = (state != IDLE);
    assign timeout_err   = err_q;
    assign points_done   = done_cnt;

endmodule

// File: tb/tb_voxel_rmw_sequencer.sv
// Directed self-checking bench for voxel_rmw_sequencer with a cache manager
// responder model (read ack after 2 cycles, write ack after 3 cycles).
module tb_voxel_rmw_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pt_valid;
    logic        pt_ready;
    logic [14:0] pt_voxel_addr;
    logic [15:0] pt_intensity;
    logic [14:0] cm_voxel_addr;
    logic [31:0] cm_data_wr;
    logic        cm_read_en;
    logic        cm_write_en;
    logic [31:0] cm_data_rd;
    logic        cm_ready;
    logic        busy;
    logic        timeout_err;
    logic [31:0] points_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:32767];
    logic        resp_on   = 1'b1;
    logic        rd_ovr_en = 1'b0;
    logic [31:0] rd_ovr    = 32'h0;
    int          inject_req = 0;
    int          inject_ack = 0;

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [14:0] rd_addr = '0;
    logic [14:0] wr_addr = '0;
    logic [31:0] wr_data_q = '0;
    logic        wr_outstanding = 1'b0;
    int          n_reads = 0;
    int          n_writes = 0;
    int          overlap_err = 0;
    int          addr_err = 0;
    int          both_err = 0;
    logic [31:0] last_wr_data = '0;
    logic [14:0] last_wr_addr = '0;
    int          exp_done = 0;

    voxel_rmw_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .pt_valid      (pt_valid),
        .pt_ready      (pt_ready),
        .pt_voxel_addr (pt_voxel_addr),
        .pt_intensity  (pt_intensity),
        .cm_voxel_addr (cm_voxel_addr),
        .cm_data_wr    (cm_data_wr),
        .cm_read_en    (cm_read_en),
        .cm_write_en   (cm_write_en),
        .cm_data_rd    (cm_data_rd),
        .cm_ready      (cm_ready),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .points_done   (points_done)
    );

    initial forever #5 clk = ~clk;

    // Cache manager model and bus monitor, evaluated on the falling edge.
    always @(negedge clk) begin
        cm_ready   = 1'b0;
        cm_data_rd = 32'h0;
        if (!rst) begin
            rd_cnt         = 0;
            wr_cnt         = 0;
            wr_outstanding = 1'b0;
            inject_ack     = inject_req;
        end else begin
            if (cm_read_en && cm_write_en) both_err++;
            if (inject_req != inject_ack) begin
                cm_ready   = 1'b1;
                inject_ack = inject_req;
            end
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    cm_ready   = 1'b1;
                    cm_data_rd = rd_ovr_en ? rd_ovr : mem[rd_addr];
                    if (cm_voxel_addr !== rd_addr) addr_err++;
                end
            end
            if (wr_cnt > 0) begin
                wr_cnt--;
                if (wr_cnt == 0) begin
                    cm_ready       = 1'b1;
                    mem[wr_addr]   = wr_data_q;
                    wr_outstanding = 1'b0;
                    if (cm_voxel_addr !== wr_addr) addr_err++;
                end
            end
            if (cm_read_en) begin
                n_reads++;
                if (wr_outstanding) overlap_err++;
                if (resp_on) begin
                    rd_cnt  = 2;
                    rd_addr = cm_voxel_addr;
                end
            end
            if (cm_write_en) begin
                n_writes++;
                last_wr_data   = cm_data_wr;
                last_wr_addr   = cm_voxel_addr;
                wr_data_q      = cm_data_wr;
                wr_addr        = cm_voxel_addr;
                wr_outstanding = 1'b1;
                if (resp_on) wr_cnt = 3;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_point(input logic [14:0] addr, input logic [15:0] inten);
        int guard;
        guard = 0;
        while (!pt_ready && guard < 200) begin
            tick();
            guard++;
        end
        checks++;
        if (!pt_ready) begin
            errors++;
            $display("[TB] FAIL accept_wait: pt_ready=%0b required 1 within 200 cycles", pt_ready);
        end
        pt_valid      = 1'b1;
        pt_voxel_addr = addr;
        pt_intensity  = inten;
        tick();
        pt_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int cycles);
        cycles = 0;
        while (busy && cycles < limit) begin
            tick();
            cycles++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("[TB] FAIL idle_wait: busy=%0b required 0 within %0d cycles", busy, limit);
        end
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        pt_valid      = 1'b1;
        pt_voxel_addr = 15'h0;
        pt_intensity  = 16'h0;
        repeat (3) tick();
        checks++;
        if (pt_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_pt_ready: got %0b want 0", pt_ready);
        end
        checks++;
        if (cm_read_en !== 1'b0 || cm_write_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_cm_en: got rd=%0b wr=%0b want 0 0", cm_read_en, cm_write_en);
        end
        checks++;
        if (points_done !== 32'd0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_status: got done=%0d busy=%0b terr=%0b want 0 0 0",
                     points_done, busy, timeout_err);
        end
        pt_valid = 1'b0;
        rst      = 1'b1;
        #1;
        checks++;
        if (pt_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_pt_ready: got %0b want 1", pt_ready);
        end
        tick();
    endtask

    task automatic test_single_point();
        int cyc;
        int w0;
        w0        = n_writes;
        rd_ovr_en = 1'b1;
        rd_ovr    = 32'h0003_0040;
        send_point(15'h1234, 16'h0050);
        wait_idle(200, cyc);
        exp_done++;
        checks++;
        if (cyc != 7) begin
            errors++;
            $display("[TB] FAIL single_latency: got %0d cycles after accept want 7", cyc);
        end
        checks++;
        if (n_writes - w0 != 1) begin
            errors++;
            $display("[TB] FAIL single_write_count: got %0d want 1", n_writes - w0);
        end
        checks++;
        if (last_wr_data !== 32'h0004_0050 || last_wr_addr !== 15'h1234) begin
            errors++;
            $display("[TB] FAIL single_write: got data=%h addr=%h want 00040050 1234",
                     last_wr_data, last_wr_addr);
        end
        checks++;
        if (points_done !== 32'(exp_done)) begin
            errors++;
            $display("[TB] FAIL single_done: got %0d want %0d", points_done, exp_done);
        end
        checks++;
        if (addr_err != 0 || both_err != 0) begin
            errors++;
            $display("[TB] FAIL single_bus: got addr_err=%0d both_err=%0d want 0 0", addr_err, both_err);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] rd_vec  [2];
        logic [15:0] int_vec [2];
        logic [31:0] exp_vec [2];
        int          cyc;
        rd_vec[0] = 32'hFFFF_00FF; int_vec[0] = 16'h0010; exp_vec[0] = 32'hFFFF_00FF;
        rd_vec[1] = 32'hFFFE_1000; int_vec[1] = 16'h2000; exp_vec[1] = 32'hFFFF_2000;
        rd_ovr_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rd_ovr = rd_vec[i];
            send_point(15'h0100, int_vec[i]);
            wait_idle(200, cyc);
            exp_done++;
            checks++;
            if (last_wr_data !== exp_vec[i]) begin
                errors++;
                $display("[TB] FAIL sat_write_%0d: got %h want %h", i, last_wr_data, exp_vec[i]);
            end
        end
        checks++;
        if (points_done !== 32'(exp_done)) begin
            errors++;
            $display("[TB] FAIL sat_done: got %0d want %0d", points_done, exp_done);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int w0;
        w0        = n_writes;
        rd_ovr_en = 1'b0;
        mem[15'h0007] = 32'h0;
        send_point(15'h0007, 16'h0020);
        send_point(15'h0007, 16'h0030);
        wait_idle(200, cyc);
        exp_done += 2;
        checks++;
        if (mem[15'h0007] !== 32'h0002_0030) begin
            errors++;
            $display("[TB] FAIL b2b_word: got %h want 00020030", mem[15'h0007]);
        end
        checks++;
        if (overlap_err != 0 || n_writes - w0 != 2) begin
            errors++;
            $display("[TB] FAIL b2b_order: got overlap=%0d writes=%0d want 0 2", overlap_err, n_writes - w0);
        end
        checks++;
        if (points_done !== 32'(exp_done)) begin
            errors++;
            $display("[TB] FAIL b2b_done: got %0d want %0d", points_done, exp_done);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        int w0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pre_timeout_err: got %0b want 0", timeout_err);
        end
        w0        = n_writes;
        resp_on   = 1'b0;
        rd_ovr_en = 1'b1;
        rd_ovr    = 32'h0;
        send_point(15'h0042, 16'h0011);
        wait_idle(200, cyc);
        checks++;
        if (cyc != 65) begin
            errors++;
            $display("[TB] FAIL timeout_latency: got %0d cycles want 65", cyc);
        end
        checks++;
        if (timeout_err !== 1'b1 || pt_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_flags: got terr=%0b pt_ready=%0b want 1 1", timeout_err, pt_ready);
        end
        checks++;
        if (n_writes != w0 || points_done !== 32'(exp_done)) begin
            errors++;
            $display("[TB] FAIL timeout_drop: got writes=%0d done=%0d want 0 %0d",
                     n_writes - w0, points_done, exp_done);
        end
        resp_on = 1'b1;
        rd_ovr  = 32'h0000_0005;
        send_point(15'h0042, 16'h0002);
        wait_idle(200, cyc);
        exp_done++;
        checks++;
        if (timeout_err !== 1'b1 || last_wr_data !== 32'h0001_0005 || points_done !== 32'(exp_done)) begin
            errors++;
            $display("[TB] FAIL timeout_sticky: got terr=%0b data=%h done=%0d want 1 00010005 %0d",
                     timeout_err, last_wr_data, points_done, exp_done);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        int r0;
        int w0;
        rd_ovr_en = 1'b1;
        rd_ovr    = 32'h0;
        send_point(15'h0055, 16'h0001);
        guard = 0;
        while (!cm_write_en && guard < 50) begin
            tick();
            guard++;
        end
        checks++;
        if (cm_write_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_write_seen: got %0b want 1", cm_write_en);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        r0  = n_reads;
        w0  = n_writes;
        rst = 1'b1;
        repeat (5) tick();
        inject_req++;
        repeat (5) tick();
        checks++;
        if (n_reads != r0 || n_writes != w0) begin
            errors++;
            $display("[TB] FAIL mid_no_pulses: got reads=%0d writes=%0d want 0 0", n_reads - r0, n_writes - w0);
        end
        checks++;
        if (points_done !== 32'd0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_status: got done=%0d busy=%0b terr=%0b want 0 0 0",
                     points_done, busy, timeout_err);
        end
    endtask

    // Run every scenario in order and report the totals.
    initial begin
        cm_ready   = 1'b0;
        cm_data_rd = 32'h0;
        test_reset();
        test_single_point();
        test_saturation();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
